cordic_sweep_ctrl: RTL and testbench

- Upstream sequencer for the CORDIC rotation stage.
- Generates an angle sweep (start, step, stop, in integer degrees, wrapping at 360) and presents each angle to the rotator.
- Waits for the rotator's result, tags it with its angle and buffers it in a small FIFO.
- Streams angle/cos/sin triples to a consumer over valid/ready, with backpressure and a per-point timeout.

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_sweep_ctrl_if.sv | 24 ++
 rtl/cordic_res_fifo.sv | 60 ++++++
 rtl/cordic_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_cordic_sweep_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sweep controller: angle width, the full
// circle in degrees, the sequencer state encoding and config validation.
package cordic_pkg;

  localparam int ANG_W    = 16;
  localparam int DEG_FULL = 360;
  localparam int ONE_Q16  = 65536;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DRAIN = 3'd4
  } sweep_state_t;

  // A sweep configuration is usable when both angles lie on the circle and
  // the step moves by at least one and less than a full turn.
  function automatic logic cfg_ok(
    input logic [ANG_W-1:0] start_ang,
    input logic [ANG_W-1:0] stop_ang,
    input logic [ANG_W-1:0] step
  );
    return (start_ang < ANG_W'(DEG_FULL)) &&
           (stop_ang  < ANG_W'(DEG_FULL)) &&
           (step != {ANG_W{1'b0}})        &&
           (step < ANG_W'(DEG_FULL));
  endfunction

endpackage

// File: rtl/cordic_sweep_ctrl_if.sv
// Result stream towards the consumer: angle/cos/sin/last with valid/ready.
interface cordic_sweep_ctrl_if #(
  parameter int DATA_W = 32
);
  import cordic_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [ANG_W-1:0]  m_angle;
  logic [DATA_W-1:0] m_cos;
  logic [DATA_W-1:0] m_sin;
  logic              m_last;

  modport master (
    output m_valid, m_angle, m_cos, m_sin, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_angle, m_cos, m_sin, m_last,
    output m_ready
  );

endinterface

// File: rtl/cordic_res_fifo.sv
// Small first-word-fall-through FIFO holding tagged rotator results. The
// storage is cleared on reset so the head word reads as zero when empty.
module cordic_res_fifo #(
  parameter int W     = 81,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage, pointers and occupancy; push+pop together leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_sweep_ctrl.sv
// Angle sweep sequencer in front of the CORDIC rotator: issues each angle,
// waits (with input-pipeline blanking and a timeout) for the result, tags it
// and buffers it for the downstream consumer.
module cordic_sweep_ctrl
  import cordic_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int BLANK_CYC   = 2,
  parameter int TIMEOUT_CYC = 63,
  parameter int MAX_PTS     = 360
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ANG_W-1:0]  i_start_ang,
  input  logic [ANG_W-1:0]  i_stop_ang,
  input  logic [ANG_W-1:0]  i_step,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_cfg,
  output logic              o_err_timeout,
  output logic [ANG_W-1:0]  o_angle,
  input  logic              i_cs_valid,
  input  logic [DATA_W-1:0] i_cos,
  input  logic [DATA_W-1:0] i_sin,
  cordic_sweep_ctrl_if.master m_if
);

  localparam int ENT_W  = ANG_W + 2 * DATA_W + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PTS_W  = $clog2(MAX_PTS + 1);
  localparam logic [WAIT_W-1:0] BLANK_V   = WAIT_W'(BLANK_CYC);
  localparam logic [WAIT_W-1:0] TOUT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [PTS_W-1:0]  PTS_LAST  = PTS_W'(MAX_PTS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_V   = CNT_W'(FIFO_DEPTH);

  sweep_state_t      r_state, w_state_nxt;
  logic [ANG_W-1:0]  r_cur, w_cur_nxt;
  logic [ANG_W-1:0]  r_stop, w_stop_nxt;
  logic [ANG_W-1:0]  r_step, w_step_nxt;
  logic [ANG_W-1:0]  r_angle, w_angle_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [PTS_W-1:0]  r_pts, w_pts_nxt;
  logic              r_err_timeout, w_err_timeout_nxt;
  logic              r_err_cfg, w_err_cfg_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy;

  logic              w_push;
  logic              w_last;
  logic [ANG_W:0]    w_sum;
  logic [ANG_W:0]    w_wrap;
  logic [ENT_W-1:0]  w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  // The final point is either the stop angle or the point-count guard.
  assign w_last = (r_cur == r_stop) || (r_pts == PTS_LAST);
  // One conditional subtract is enough since cur and step are both < 360.
  assign w_sum  = {1'b0, r_cur} + {1'b0, r_step};
  assign w_wrap = (w_sum >= (ANG_W+1)'(DEG_FULL)) ? (w_sum - (ANG_W+1)'(DEG_FULL)) : w_sum;

  // Sequencer state register and its datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cur         <= {ANG_W{1'b0}};
      r_stop        <= {ANG_W{1'b0}};
      r_step        <= {ANG_W{1'b0}};
      r_angle       <= {ANG_W{1'b0}};
      r_wait        <= {WAIT_W{1'b0}};
      r_pts         <= {PTS_W{1'b0}};
      r_err_timeout <= 1'b0;
      r_err_cfg     <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur         <= w_cur_nxt;
      r_stop        <= w_stop_nxt;
      r_step        <= w_step_nxt;
      r_angle       <= w_angle_nxt;
      r_wait        <= w_wait_nxt;
      r_pts         <= w_pts_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_err_cfg     <= w_err_cfg_nxt;
      r_done        <= w_done_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and datapath updates for IDLE/ISSUE/WAIT/NEXT/DRAIN.
  always_comb begin
    w_state_nxt       = r_state;
    w_cur_nxt         = r_cur;
    w_stop_nxt        = r_stop;
    w_step_nxt        = r_step;
    w_angle_nxt       = r_angle;
    w_wait_nxt        = r_wait;
    w_pts_nxt         = r_pts;
    w_err_timeout_nxt = r_err_timeout;
    w_err_cfg_nxt     = 1'b0;
    w_done_nxt        = 1'b0;
    w_push            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && w_empty) begin
          if (!cfg_ok(i_start_ang, i_stop_ang, i_step)) begin
            w_err_cfg_nxt = 1'b1;
          end else begin
            w_cur_nxt         = i_start_ang;
            w_stop_nxt        = i_stop_ang;
            w_step_nxt        = i_step;
            w_pts_nxt         = {PTS_W{1'b0}};
            w_err_timeout_nxt = 1'b0;
            w_state_nxt       = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The angle is presented even while stalled on a full buffer.
        w_angle_nxt = r_cur;
        if (w_count < DEPTH_V) begin
          w_wait_nxt  = {WAIT_W{1'b0}};
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if ((r_wait >= BLANK_V) && i_cs_valid && !w_full) begin
          w_push      = 1'b1;
          w_state_nxt = ST_NEXT;
        end else if (r_wait == TOUT_LAST) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = ST_NEXT;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      ST_NEXT: begin
        w_pts_nxt = r_pts + PTS_W'(1);
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_cur_nxt   = w_wrap[ANG_W-1:0];
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  cordic_res_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_cur, i_cos, i_sin, w_last}),
    .i_pop   (m_if.m_valid && m_if.m_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err_cfg     = r_err_cfg;
  assign o_err_timeout = r_err_timeout;
  assign o_angle       = r_angle;

  assign m_if.m_valid  = !w_empty;
  assign m_if.m_angle  = w_head[ENT_W-1 -: ANG_W];
  assign m_if.m_cos    = w_head[2*DATA_W -: DATA_W];
  assign m_if.m_sin    = w_head[DATA_W -: DATA_W];
  assign m_if.m_last   = w_head[0];

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Randomized bench for cordic_sweep_ctrl with a list-based sweep model.
module tb_cordic_sweep_ctrl;
  import cordic_pkg::*;

  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 63;
  localparam int MAX_PTS     = 360;

  typedef struct {
    int          ang;
    logic [31:0] c;
    logic [31:0] s;
    logic        last;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_start_ang = 16'd0;
  logic [15:0] i_stop_ang = 16'd0;
  logic [15:0] i_step = 16'd0;
  logic        o_busy, o_done, o_err_cfg, o_err_timeout;
  logic [15:0] o_angle;
  logic        cs_valid;
  logic [31:0] cos_v, sin_v;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int errcfg_cnt = 0;
  int popped = 0;
  ent_t exp_q[$];

  // rotator model state
  int          rot_delay = 18;
  int          drop_ang = -1;
  logic [31:0] salt = 32'd0;
  logic [15:0] prev_ang = 16'd0;
  int          stab = 0;
  bit          ready_rand = 1'b0;
  logic        ready_lvl = 1'b1;

  cordic_sweep_ctrl_if #(.DATA_W(DATA_W)) m_if ();

  cordic_sweep_ctrl #(
    .DATA_W(DATA_W), .FIFO_DEPTH(4), .BLANK_CYC(2),
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_PTS(MAX_PTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_start_ang(i_start_ang), .i_stop_ang(i_stop_ang), .i_step(i_step),
    .o_busy(o_busy), .o_done(o_done), .o_err_cfg(o_err_cfg),
    .o_err_timeout(o_err_timeout), .o_angle(o_angle),
    .i_cs_valid(cs_valid), .i_cos(cos_v), .i_sin(sin_v), .m_if(m_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cos_of(input int a);
    return salt + 32'(a * ONE_Q16);
  endfunction

  function automatic logic [31:0] sin_of(input int a);
    return ~salt - 32'(a);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rotator: result becomes valid once the presented angle has been stable
  // for rot_delay cycles (restarted by a new angle or an accepted start).
  always @(posedge clk) begin
    prev_ang <= o_angle;
    if (i_start && !o_busy) stab <= 0;
    else if (o_angle != prev_ang) stab <= 0;
    else if (stab < 1000) stab <= stab + 1;
  end

  always @* begin
    cs_valid = (stab >= rot_delay) && (int'(o_angle) != drop_ang);
    cos_v    = cos_of(int'(o_angle));
    sin_v    = sin_of(int'(o_angle));
  end

  // Consumer ready, changed just after each rising edge.
  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_lvl;
    end
  end

  // Output monitor / scoreboard and pulse counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_done) done_cnt++;
      if (o_err_cfg) errcfg_cnt++;
      if (m_if.m_valid && m_if.m_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          check_eq("extra_entry", {48'd0, m_if.m_angle}, 64'hFFFF);
        end else begin
          check_eq("m_angle", {48'd0, m_if.m_angle}, 64'(exp_q[0].ang));
          check_eq("m_cos", {32'd0, m_if.m_cos}, {32'd0, exp_q[0].c});
          check_eq("m_sin", {32'd0, m_if.m_sin}, {32'd0, exp_q[0].s});
          check_eq("m_last", {63'd0, m_if.m_last}, {63'd0, exp_q[0].last});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic begin_sweep(input int s, input int e, input int st, input int dly,
                             input int drop, input bit rr,
                             output int npts, output bit exp_to);
    int  a;
    int  n;
    bit  lst;
    salt       = $urandom;
    rot_delay  = dly;
    drop_ang   = drop;
    ready_rand = rr;
    exp_q.delete();
    exp_to = 1'b0;
    a = s;
    n = 0;
    forever begin
      lst = (a == e) || (n == MAX_PTS - 1);
      if (a == drop) exp_to = 1'b1;
      else exp_q.push_back('{ang: a, c: cos_of(a), s: sin_of(a), last: lst});
      if (lst) break;
      a = (a + st) % DEG_FULL;
      n++;
    end
    npts = n + 1;
    done_cnt = 0;
    errcfg_cnt = 0;
    @(negedge clk);
    i_start_ang = 16'(s);
    i_stop_ang  = 16'(e);
    i_step      = 16'(st);
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("busy_after_start", {63'd0, o_busy}, 64'd1);
    check_eq("err_to_cleared", {63'd0, o_err_timeout}, 64'd0);
  endtask

  task automatic finish_sweep(input int npts, input bit exp_to, input bit poke);
    int  cyc;
    bit  ended;
    ended = 1'b0;
    for (cyc = 0; cyc < 60 * npts + 600; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 40) begin
        i_start_ang = 16'd10; i_stop_ang = 16'd20; i_step = 16'd5; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      if (!o_busy) begin
        ended = 1'b1;
        break;
      end
    end
    i_start = 1'b0;
    check_eq("sweep_ended", {63'd0, ended}, 64'd1);
    repeat (2) @(negedge clk);
    check_eq("missing_entries", 64'(exp_q.size()), 64'd0);
    check_eq("done_pulses", 64'(done_cnt), 64'd1);
    check_eq("err_cfg_pulses", 64'(errcfg_cnt), 64'd0);
    check_eq("err_timeout", {63'd0, o_err_timeout}, {63'd0, exp_to});
    check_eq("m_valid_idle", {63'd0, m_if.m_valid}, 64'd0);
  endtask

  task automatic cfg_err(input int s, input int e, input int st);
    @(negedge clk);
    i_start_ang = 16'(s);
    i_stop_ang  = 16'(e);
    i_step      = 16'(st);
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("err_cfg_pulse", {63'd0, o_err_cfg}, 64'd1);
    check_eq("busy_after_bad", {63'd0, o_busy}, 64'd0);
    @(negedge clk);
    check_eq("err_cfg_one_cycle", {63'd0, o_err_cfg}, 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_ctl"}, {59'd0, o_busy, o_done, o_err_cfg, o_err_timeout, m_if.m_valid}, 64'd0);
    check_eq({tag, "_angle"}, {48'd0, o_angle}, 64'd0);
    check_eq({tag, "_head"}, {15'd0, m_if.m_angle, m_if.m_cos[15:0], m_if.m_sin[15:0], m_if.m_last}, 64'd0);
  endtask

  initial begin
    int  np;
    bit  eto;
    int  cyc;
    int  win;
    int  s, st, k;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("post_reset");

    // Quadrant sweep with a start attempt while busy.
    begin_sweep(0, 270, 90, 18, -1, 1'b0, np, eto);
    finish_sweep(np, eto, 1'b1);
    check_eq("quad_popped", 64'(popped), 64'd4);

    // Wrap through 360.
    begin_sweep(300, 30, 45, 18, -1, 1'b0, np, eto);
    finish_sweep(np, eto, 1'b0);

    // Backpressure: consumer stalled for the whole sweep, then released.
    ready_lvl = 1'b0;
    popped = 0;
    begin_sweep(0, 350, 10, 18, -1, 1'b0, np, eto);
    repeat (400) @(negedge clk);
    check_eq("bp_popped", 64'(popped), 64'd0);
    check_eq("bp_valid", {63'd0, m_if.m_valid}, 64'd1);
    check_eq("bp_head", {48'd0, m_if.m_angle}, 64'd0);
    check_eq("bp_angle_o", {48'd0, o_angle}, 64'd40);
    check_eq("bp_busy", {63'd0, o_busy}, 64'd1);
    ready_lvl = 1'b1;
    finish_sweep(np, eto, 1'b0);
    check_eq("bp_total", 64'(popped), 64'd36);

    // Timeout on angle 90: it must stay presented for the full wait window.
    begin_sweep(0, 180, 90, 18, 90, 1'b0, np, eto);
    for (cyc = 0; cyc < 300 && o_angle != 16'd90; cyc++) @(negedge clk);
    check_eq("to_err_before", {63'd0, o_err_timeout}, 64'd0);
    win = 0;
    for (cyc = 0; cyc < 300 && o_angle == 16'd90; cyc++) begin
      @(negedge clk);
      win++;
    end
    check_eq("to_window", 64'(win), 64'(TIMEOUT_CYC + 2));
    check_eq("to_err_set", {63'd0, o_err_timeout}, 64'd1);
    finish_sweep(np, eto, 1'b0);

    // Rejected configurations.
    cfg_err(0, 90, 0);
    cfg_err(400, 90, 10);
    cfg_err(0, 360, 10);
    cfg_err(0, 90, 360);
    check_eq("err_to_kept_idle", {63'd0, o_err_timeout}, 64'd1);

    // Reset during the second point's wait, then a clean sweep.
    begin_sweep(0, 180, 90, 18, -1, 1'b0, np, eto);
    for (cyc = 0; cyc < 300 && o_angle != 16'd90; cyc++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin_sweep(0, 180, 90, 18, -1, 1'b0, np, eto);
    finish_sweep(np, eto, 1'b0);

    // Point-count guard: stop angle never reached.
    begin_sweep(0, 1, 2, 0, -1, 1'b0, np, eto);
    finish_sweep(np, eto, 1'b0);

    // Random sweeps with random consumer stalls.
    for (int i = 0; i < 6; i++) begin
      s  = $urandom_range(0, 359);
      st = $urandom_range(1, 359);
      k  = $urandom_range(0, 15);
      begin_sweep(s, (s + st * k) % DEG_FULL, st, $urandom_range(0, 30), -1, 1'b1, np, eto);
      finish_sweep(np, eto, 1'b0);
    end
    ready_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
